ext_fifo_tap: RTL and testbench
===============================

Name: ext_fifo_tap

Overview:
- Multi-channel successor to the processor's single-address extraction FIFO intercept.
- Snoops the processor-to-data-cache request bus and captures qualifying stores that fall inside a window of CHANNELS consecutive word addresses.
- Each captured store is buffered with its channel index and byte enables in an internal FIFO, which drains over a valid/ready stream.
- Supports a lossy mode (drop and count on full) and a lossless mode (back-pressures the pipeline).

Parameters:
- DATA_WIDTH, 32, store data width.
- ADDR_WIDTH, 32, processor address width.
- BASE_ADDR, 32'h00010150, address of channel 0.
- CHANNELS, 4, number of tapped addresses; power of two, 1..16.
- ADDR_STRIDE, 4, byte distance between channel addresses; power of two, at least 4.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries.
- STALL_MODE, 0, 0 means drop on full, 1 means assert TAP_STALL and never drop.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CONTROL_FROM_PROC  in  2  request type: 00 idle, 01 read, 10 write, 11 flush.
- ADDR_FROM_PROC  in  ADDR_WIDTH  request byte address.
- DATA_FROM_PROC  in  DATA_WIDTH  store data.
- BYTE_ENB_FROM_PROC  in  DATA_WIDTH/8  store byte enables.
- CACHE_READY_DAT  in  1  data cache ready.
- CACHE_READY_INS  in  1  instruction cache ready.
- TAP_STALL  out  1  back-pressure request to the pipeline; STALL_MODE=1 only.
- M_VALID  out  1  output stream valid.
- M_READY  in  1  output stream ready.
- M_DATA  out  DATA_WIDTH  captured store data.
- M_CHANNEL  out  max(1,log2(CHANNELS))  channel index.
- M_BYTE_ENB  out  DATA_WIDTH/8  captured byte enables.
- FIFO_LEVEL  out  DEPTH_LOG2+1  current occupancy.
- DROP_COUNT  out  16  number of dropped captures; saturates.

Behaviour:
- Capture condition (cycle t): CONTROL_FROM_PROC==2'b10, CACHE_READY_DAT, CACHE_READY_INS, (ADDR-BASE_ADDR) < CHANNELS*ADDR_STRIDE (unsigned), and (ADDR-BASE_ADDR) mod ADDR_STRIDE == 0. Misaligned or out-of-window stores are ignored.
- Channel index = (ADDR-BASE_ADDR) >> log2(ADDR_STRIDE).
- Stage 1: at edge t, the capture is registered together with data, byte enables and channel. Stage-1 valid is set only by a capture.
- At edge t+1, the stage-1 entry is pushed into the FIFO, so it is visible on M_* from cycle t+2. Latency is 2 cycles, one more than the original single-address intercept.
- FIFO is first-word-fall-through: M_VALID = not empty, and M_* show the head entry. A pop occurs when M_VALID & M_READY at an edge.
- While M_VALID=1 and M_READY=0, M_DATA, M_CHANNEL and M_BYTE_ENB are held stable.
- Push into a full FIFO with a pop in the same cycle: both are accepted and the level is unchanged.
- Push into a full FIFO without a pop: the entry is discarded and DROP_COUNT increments, saturating at 16'hFFFF.
- Push into an empty FIFO with M_READY=1: the entry still appears for at least one cycle. There is no bypass.
- STALL_MODE=1: TAP_STALL = (FIFO_LEVEL + stage1_valid) >= 2^DEPTH_LOG2 - 1. This is decoded only from registers, with no combinational path from the inputs. One capture may still land after the assertion, and the margin guarantees no drop.
- STALL_MODE=0: TAP_STALL is tied to 0.
- Read pointer, write pointer and level use DEPTH_LOG2+1 bits and wrap modulo 2^DEPTH_LOG2 on the pointer index.
- Reset (including mid-stream): stage1_valid=0, pointers=0, FIFO_LEVEL=0, M_VALID=0, TAP_STALL=0, DROP_COUNT=0. M_DATA, M_CHANNEL and M_BYTE_ENB read 0. FIFO contents are not cleared.
- A capture in the same cycle that RST is asserted is lost.

Decomposition:
- Shared package holds:
  - CTRL_IDLE/CTRL_READ/CTRL_WRITE/CTRL_FLUSH encodings (2'b00..2'b11);
  - default EXT_FIFO base address 32'h00010150;
  - the logb2 function.
- One sub-module: sync_fifo_fwft.
  - Parameters: WIDTH and DEPTH_LOG2.
  - Ports: push/pop, full/empty, level.
  - Entry width = DATA_WIDTH + DATA_WIDTH/8 + channel bits.

Test Plan:
- Store 32'hDEADBEEF, byte enables 4'hF, to 32'h00010158 with both readies high, M_READY=1. Required: M_VALID at t+2 with M_CHANNEL=2, M_DATA=32'hDEADBEEF, held for one cycle; FIFO_LEVEL returns to 0.
- Stores to 32'h00010160 (out of window), 32'h00010152 (misaligned), a read to 32'h00010150, and a store to 32'h00010150 with CACHE_READY_INS=0. Required: no M_VALID, FIFO_LEVEL stays 0.
- STALL_MODE=0, M_READY=0, 20 back-to-back valid stores. Required: FIFO_LEVEL=16, DROP_COUNT=4; then draining gives data in order for the first 16 stores.
- STALL_MODE=1, M_READY=0, the bench holds stores while TAP_STALL=1. Required: TAP_STALL is asserted once level+pending reaches 15, FIFO_LEVEL never exceeds 16, DROP_COUNT stays 0.
- FIFO full, push and pop in the same cycle. Required: level stays 16, DROP_COUNT unchanged, and the new entry is the last one out.
- RST pulsed with FIFO_LEVEL=7 and a capture in stage 1. Required: next cycle M_VALID=0, FIFO_LEVEL=0, DROP_COUNT=0; a subsequent store is the first entry out.

Source files
------------

// File: rtl/ext_fifo_tap_pkg.sv
// Shared definitions for the extraction FIFO tap: request encodings,
// the default tap base address and a constant-evaluable log2 helper.
package ext_fifo_tap_pkg;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;
  localparam logic [1:0] CTRL_FLUSH = 2'b11;

  localparam logic [31:0] EXT_FIFO_BASE_ADDR = 32'h00010150;

  // Ceiling log2; logb2(1) = 0.
  function automatic int logb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ext_fifo_tap_fifo.sv
// First-word-fall-through synchronous FIFO. Storage is a plain array
// with a registered read port; the head register is loaded with the entry
// that will be at the head after each edge, forwarding the write data
// when the entry being written is the one about to become the head.
module sync_fifo_fwft
  import ext_fifo_tap_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_reg;
  logic [DEPTH_LOG2:0]   rd_ptr_reg;
  logic [DEPTH_LOG2:0]   wr_ptr_next;
  logic [DEPTH_LOG2:0]   rd_ptr_next;
  logic [WIDTH-1:0]      head_reg;
  logic [WIDTH-1:0]      head_next;
  logic                  push_ok;
  logic                  pop_ok;

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign pop_ok      = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok     = push & (~full | pop_ok);
  assign wr_ptr_next = wr_ptr_reg + {{DEPTH_LOG2{1'b0}}, push_ok};
  assign rd_ptr_next = rd_ptr_reg + {{DEPTH_LOG2{1'b0}}, pop_ok};
  assign head_data   = head_reg;

  // Next head entry: forward the write when it lands on the next read slot.
  always_comb begin
    head_next = mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    if (push_ok && (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0])) begin
      head_next = push_data;
    end
  end

  // Storage write; contents are intentionally left untouched by reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= push_data;
  end

  // Pointer and head register update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
    end
  end

endmodule

// File: rtl/ext_fifo_tap.sv
// Store-snooping tap: captures writes to a window of consecutive word
// addresses, registers them for one cycle, then queues them in a FWFT
// FIFO that drains over a valid/ready stream.
module ext_fifo_tap
  import ext_fifo_tap_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(EXT_FIFO_BASE_ADDR),
  parameter int                    CHANNELS    = 4,
  parameter int                    ADDR_STRIDE = 4,
  parameter int                    DEPTH_LOG2  = 4,
  parameter int                    STALL_MODE  = 0,
  localparam int                   CH_W        = (CHANNELS > 1) ? logb2(CHANNELS) : 1,
  localparam int                   BE_W        = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            CONTROL_FROM_PROC,
  input  logic [ADDR_WIDTH-1:0] ADDR_FROM_PROC,
  input  logic [DATA_WIDTH-1:0] DATA_FROM_PROC,
  input  logic [BE_W-1:0]       BYTE_ENB_FROM_PROC,
  input  logic                  CACHE_READY_DAT,
  input  logic                  CACHE_READY_INS,
  output logic                  TAP_STALL,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [CH_W-1:0]       M_CHANNEL,
  output logic [BE_W-1:0]       M_BYTE_ENB,
  output logic [DEPTH_LOG2:0]   FIFO_LEVEL,
  output logic [15:0]           DROP_COUNT
);

  localparam int STRIDE_SH = logb2(ADDR_STRIDE);
  localparam int ENTRY_W   = DATA_WIDTH + BE_W + CH_W;
  localparam logic [ADDR_WIDTH-1:0] WINDOW_BYTES = ADDR_WIDTH'(CHANNELS * ADDR_STRIDE);

  logic [ADDR_WIDTH-1:0] addr_offset;
  logic [CH_W-1:0]       capture_channel;
  logic                  capture;
  logic                  s1_valid_reg;
  logic [ENTRY_W-1:0]    s1_entry_reg;
  logic [ENTRY_W-1:0]    head_entry;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BE_W-1:0]       head_be;
  logic [CH_W-1:0]       head_channel;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  drop;
  logic [15:0]           drop_count_reg;

  // Unsigned offset: addresses below the base wrap high and fail the window test.
  assign addr_offset     = ADDR_FROM_PROC - BASE_ADDR;
  assign capture_channel = addr_offset[STRIDE_SH +: CH_W];
  assign capture = (CONTROL_FROM_PROC == CTRL_WRITE) && CACHE_READY_DAT && CACHE_READY_INS
                   && (addr_offset < WINDOW_BYTES)
                   && (addr_offset[STRIDE_SH-1:0] == '0);

  // Stage 1: register the qualifying store with its channel and byte enables.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s1_entry_reg <= '0;
    end else begin
      s1_valid_reg <= capture;
      if (capture) s1_entry_reg <= {DATA_FROM_PROC, BYTE_ENB_FROM_PROC, capture_channel};
    end
  end

  assign fifo_pop = ~fifo_empty & M_READY;
  assign drop     = s1_valid_reg & fifo_full & ~fifo_pop;

  sync_fifo_fwft #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (s1_valid_reg),
    .push_data (s1_entry_reg),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Saturating count of captures discarded on a full FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_count_reg <= '0;
    end else if (drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign {head_data, head_be, head_channel} = head_entry;

  // Stream outputs read zero while the FIFO is empty, so stale storage never shows.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign M_DATA[gi*8 +: 8] = fifo_empty ? 8'h00 : head_data[gi*8 +: 8];
      assign M_BYTE_ENB[gi]    = ~fifo_empty & head_be[gi];
    end
  endgenerate

  assign M_CHANNEL  = fifo_empty ? '0 : head_channel;
  assign M_VALID    = ~fifo_empty;
  assign FIFO_LEVEL = fifo_level;
  assign DROP_COUNT = drop_count_reg;

  // Stall one entry early so a capture already in flight still fits.
  generate
    if (STALL_MODE != 0) begin : g_stall
      localparam int DEPTH = 1 << DEPTH_LOG2;
      logic [DEPTH_LOG2+1:0] pending_total;
      assign pending_total = {1'b0, fifo_level} + {{(DEPTH_LOG2 + 1){1'b0}}, s1_valid_reg};
      assign TAP_STALL     = (pending_total >= (DEPTH_LOG2 + 2)'(DEPTH - 1));
    end else begin : g_no_stall
      assign TAP_STALL = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_ext_fifo_tap.sv
// Bench for ext_fifo_tap: one lossy and one lossless instance share the
// same stimulus and are compared every cycle against a queue-based model.
module tb_ext_fifo_tap;

  localparam logic [31:0] BASE = 32'h00010150;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [3:0]  be_in;
  logic        rdy_dat;
  logic        rdy_ins;
  logic        m_ready;

  logic        stall0, valid0, stall1, valid1;
  logic [31:0] data0, data1;
  logic [1:0]  ch0, ch1;
  logic [3:0]  be0, be1;
  logic [4:0]  level0, level1;
  logic [15:0] drops0, drops1;

  always #5 clk = ~clk;

  ext_fifo_tap #(.STALL_MODE(0)) dut0 (
    .CLK(clk), .RST(rst), .CONTROL_FROM_PROC(ctrl), .ADDR_FROM_PROC(addr_in),
    .DATA_FROM_PROC(data_in), .BYTE_ENB_FROM_PROC(be_in), .CACHE_READY_DAT(rdy_dat),
    .CACHE_READY_INS(rdy_ins), .TAP_STALL(stall0), .M_VALID(valid0), .M_READY(m_ready),
    .M_DATA(data0), .M_CHANNEL(ch0), .M_BYTE_ENB(be0), .FIFO_LEVEL(level0),
    .DROP_COUNT(drops0)
  );

  ext_fifo_tap #(.STALL_MODE(1)) dut1 (
    .CLK(clk), .RST(rst), .CONTROL_FROM_PROC(ctrl), .ADDR_FROM_PROC(addr_in),
    .DATA_FROM_PROC(data_in), .BYTE_ENB_FROM_PROC(be_in), .CACHE_READY_DAT(rdy_dat),
    .CACHE_READY_INS(rdy_ins), .TAP_STALL(stall1), .M_VALID(valid1), .M_READY(m_ready),
    .M_DATA(data1), .M_CHANNEL(ch1), .M_BYTE_ENB(be1), .FIFO_LEVEL(level1),
    .DROP_COUNT(drops1)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   ms1_v = 1'b0;
  ent_t ms1;
  int   mdrops = 0;

  always @(posedge clk) begin
    logic [31:0] off;
    ent_t        e;
    bit          cap;
    bit          popped;
    off    = addr_in - BASE;
    cap    = (ctrl == 2'b10) && rdy_dat && rdy_ins && (off < 32'd16) && (off % 4 == 0);
    e.d    = data_in;
    e.ch   = 2'(off >> 2);
    e.be   = be_in;
    if (rst) begin
      mq.delete();
      ms1_v  = 1'b0;
      mdrops = 0;
    end else begin
      popped = (mq.size() > 0) && m_ready;
      if (popped) void'(mq.pop_front());
      if (ms1_v) begin
        if (mq.size() < 16) mq.push_back(ms1);
        else if (mdrops < 65535) mdrops++;
      end
      ms1_v = cap;
      ms1   = e;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    ent_t head;
    bit   ev;
    if (cmp_en) begin
      ev   = (mq.size() > 0);
      head = ev ? mq[0] : '0;
      check("valid0", valid0, ev);
      check("valid1", valid1, ev);
      check("data0", data0, head.d);
      check("data1", data1, head.d);
      check("chan0", ch0, head.ch);
      check("chan1", ch1, head.ch);
      check("be0", be0, head.be);
      check("be1", be1, head.be);
      check("level0", level0, mq.size());
      check("level1", level1, mq.size());
      check("drops0", drops0, mdrops);
      check("drops1", drops1, mdrops);
      check("stall0", stall0, 1'b0);
      check("stall1", stall1, (mq.size() + ms1_v) >= 15);
      if (valid0 && m_ready)
        $display("pop ch=%0d data=%h be=%h level=%0d", ch0, data0, be0, level0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic rd, input logic ri);
    ctrl = c; addr_in = a; data_in = d; be_in = b; rdy_dat = rd; rdy_ins = ri;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_out, last_out;
    bit          stall_prev;
    int          max_level;
    int          r;

    rst = 1'b1; m_ready = 1'b0; idle();
    repeat (3) step();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_valid", valid0, 1'b0);
    check("rst_level", level1, 5'd0);
    check("rst_drops", drops0, 16'd0);
    check("rst_stall", stall1, 1'b0);
    check("rst_data", data0, 32'h0);

    // Single store to channel 2, streamed straight out.
    m_ready = 1'b1;
    drive(2'b10, 32'h00010158, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    step(); idle();
    step();
    check("t1_valid", valid0, 1'b1);
    check("t1_chan", ch0, 2'd2);
    check("t1_data", data0, 32'hDEADBEEF);
    step();
    check("t1_valid_gone", valid0, 1'b0);
    check("t1_level", level0, 5'd0);

    // Non-qualifying requests.
    drive(2'b10, 32'h00010160, 32'h1, 4'hF, 1'b1, 1'b1); step();
    drive(2'b10, 32'h00010152, 32'h2, 4'hF, 1'b1, 1'b1); step();
    drive(2'b01, 32'h00010150, 32'h3, 4'hF, 1'b1, 1'b1); step();
    drive(2'b10, 32'h00010150, 32'h4, 4'hF, 1'b1, 1'b0); step();
    idle();
    repeat (3) begin
      step();
      check("ign_valid", valid0, 1'b0);
    end
    check("ign_level", level0, 5'd0);

    // Lossy overflow: 20 stores with the stream stalled.
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(2'b10, BASE + 32'(4 * (i % 4)), 32'h10000000 + 32'(i), 4'(i), 1'b1, 1'b1);
      step();
    end
    idle(); step();
    check("ovf_level", level0, 5'd16);
    check("ovf_drops", drops0, 16'd4);

    // Full FIFO: push and pop in the same cycle.
    drive(2'b10, BASE + 32'd12, 32'hCAFE0001, 4'hA, 1'b1, 1'b1);
    step(); idle(); m_ready = 1'b1;
    step(); m_ready = 1'b0;
    check("pp_level", level0, 5'd16);
    check("pp_drops", drops0, 16'd4);
    m_ready = 1'b1;
    first_out = data0;
    last_out  = data0;
    for (int i = 0; i < 16; i++) begin
      last_out = data0;
      step();
    end
    m_ready = 1'b0;
    check("drain_first", first_out, 32'h10000001);
    check("drain_last", last_out, 32'hCAFE0001);
    check("drain_level", level0, 5'd0);

    // Reset mid-stream with 7 queued and one in stage 1.
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, BASE + 32'(4 * (i % 4)), 32'h20000000 + 32'(i), 4'hF, 1'b1, 1'b1);
      step();
    end
    check("mid_level", level0, 5'd7);
    rst = 1'b1;
    drive(2'b10, BASE, 32'h2000FFFF, 4'hF, 1'b1, 1'b1);
    step();
    rst = 1'b0; idle();
    check("mr_valid", valid0, 1'b0);
    check("mr_level", level0, 5'd0);
    check("mr_drops", drops0, 16'd0);
    check("mr_data", data0, 32'h0);
    m_ready = 1'b1;
    drive(2'b10, BASE + 32'd4, 32'hABCD0001, 4'h3, 1'b1, 1'b1);
    step(); idle();
    step();
    check("mr_first", data0, 32'hABCD0001);
    check("mr_first_ch", ch0, 2'd1);
    step();
    m_ready = 1'b0;

    // Lossless mode: pipeline reacts to TAP_STALL one cycle late.
    stall_prev = 1'b0;
    max_level  = 0;
    for (int i = 0; i < 30; i++) begin
      if (!stall_prev) drive(2'b10, BASE + 32'(4 * (i % 4)), 32'h30000000 + 32'(i), 4'hF, 1'b1, 1'b1);
      else idle();
      stall_prev = stall1;
      step();
      if (int'(level1) > max_level) max_level = int'(level1);
    end
    idle(); step();
    check("stl_asserted", stall1, 1'b1);
    check("stl_level", level1, 5'd16);
    check("stl_max", max_level, 16);
    check("stl_drops", drops1, 16'd0);

    // Randomized traffic, still honouring the lossless stall.
    stall_prev = 1'b0;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 7);
      drive((r < 4) ? 2'b10 : 2'(r - 4), 32'h00010140 + 32'($urandom_range(0, 39)),
            $urandom, 4'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
      if (stall_prev) ctrl = 2'b00;
      m_ready    = ($urandom_range(0, 3) != 0) ? (i > 250) || ($urandom_range(0, 1) == 1) : 1'b0;
      stall_prev = stall1;
      step();
    end
    idle(); m_ready = 1'b1;
    repeat (20) step();
    check("rnd_drops1", drops1, 16'd0);
    check("rnd_empty", level1, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
